// File: rtl/regfile.sv
// MIPS general-purpose register file: 32 x Width entries, two combinational
// read ports, one synchronous write port; r0 reads zero. Optional MIPS_RF_BYPASS_EN.
module regfile #(
  parameter int Width = 32,
  parameter int Depth = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [4:0]       wa,
  input  logic [Width-1:0] wd,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  output logic [Width-1:0] rd1,
  output logic [Width-1:0] rd2
);

  localparam int AW = 5;

  // Entry 0 has no storage; only entries 1..Depth-1 are flops.
  logic [Width-1:0] mem [1:Depth-1];
  logic [Depth-1:0] wen;
  logic [Width-1:0] rd1_stored;
  logic [Width-1:0] rd2_stored;

  // One-hot write enable; bit 0 forced low so r0 can never be written.
  always_comb begin
    wen = '0;
    for (int i = 1; i < Depth; i++) begin
      wen[i] = we && (wa == AW'(i));
    end
    wen[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 1; i < Depth; i++) begin
        if (wen[i]) begin
          mem[i] <= wd;
        end
      end
    end
  end

  // Read muxes over stored state; an address of 0 matches no entry and yields 0.
  always_comb begin
    rd1_stored = '0;
    rd2_stored = '0;
    for (int i = 1; i < Depth; i++) begin
      if (ra1 == AW'(i)) begin
        rd1_stored = mem[i];
      end
      if (ra2 == AW'(i)) begin
        rd2_stored = mem[i];
      end
    end
  end

`ifdef MIPS_RF_BYPASS_EN
  // Forward write data to a reader of the same nonzero address in the write cycle.
  always_comb begin
    rd1 = rd1_stored;
    rd2 = rd2_stored;
    if (we && (wa != '0) && (ra1 == wa)) begin
      rd1 = wd;
    end
    if (we && (wa != '0) && (ra2 == wa)) begin
      rd2 = wd;
    end
  end
`else
  always_comb begin
    rd1 = rd1_stored;
    rd2 = rd2_stored;
  end
`endif

endmodule
